rr_priority_arbiter: RTL and testbench
======================================

// Module: rr_priority_arbiter
// PURPOSE
//   Parametrised, registered successor to the 4:2 combinational priority encoder.
//   Takes N request lines and returns one registered grant as a one-hot vector
//   plus an encoded index and a valid flag.
//   Supports fixed-priority mode (highest index wins) or round-robin mode.
//   A LOCK input holds the current grant for multi-cycle ownership.
//   Sits between N requesters and a shared resource (bus, port, FIFO write side).
// PARAMETERS
//   N     8   number of request lines; N >= 2
//   RR    1   0 = fixed priority (highest index wins); 1 = round-robin
//   W     $clog2(N)   localparam, width of ENC
// PORTS
//   CLK    in   1   rising-edge clock, single clock domain
//   RST_N  in   1   asynchronous active-low reset
//   REQ    in   N   request vector; bit i high = requester i wants the resource
//   LOCK   in   1   while high, hold the current grant (see BEHAVIOUR)
//   GNT    out  N   registered one-hot grant; all-zero when VLD=0
//   ENC    out  W   registered binary index of the granted bit; 0 when VLD=0
//   VLD    out  1   registered; high when GNT holds a valid grant
// BEHAVIOUR
//   - Reset (RST_N=0, takes effect immediately, no clock edge needed):
//     GNT=0, ENC=0, VLD=0, internal pointer PTR=0.
//   - Latency: exactly 1 cycle. Outputs at edge k+1 reflect REQ/LOCK sampled
//     at edge k.
//   - Hold: if VLD=1 && LOCK=1 && REQ[ENC]=1, keep GNT/ENC/VLD unchanged.
//     PTR is also unchanged.
//   - Otherwise re-arbitrate each cycle:
//       REQ==0 -> VLD=0, GNT=0, ENC=0; PTR unchanged.
//       RR=0   -> winner = highest set index of REQ.
//       RR=1   -> search ascending from PTR: PTR, PTR+1, ..., N-1, 0, ...,
//                 PTR-1; first set bit wins.
//       On a grant to index i: VLD=1, ENC=i, GNT=1<<i.
//       In RR mode only, PTR <= (i+1) mod N; wrap from N-1 goes to 0.
//   - Lock release by drop: if LOCK=1 but REQ[ENC]=0, re-arbitrate normally
//     in the same cycle. No idle cycle is inserted.
//   - LOCK with VLD=0 has no effect.
//   - PTR is W bits wide and always < N. For non-power-of-2 N, the wrap is
//     an explicit compare against N-1.
//   - Requests are not latched. A request that is dropped before winning
//     is lost.
//   - Invariants (check in bench):
//       GNT is zero or one-hot.
//       GNT == (VLD << ENC).
//       VLD=1 implies the granted bit was set in REQ at the sampling edge.
// TESTING  (N=8 unless noted)
//   1. Assert RST_N=0 mid-cycle with REQ=8'hFF
//      -> GNT=0, ENC=0, VLD=0 before the next edge.
//      After release, RR=1 -> first grant is ENC=0.
//   2. RR=0, REQ=8'b0010_1100 -> next edge ENC=5, GNT=8'h20, VLD=1.
//      Then REQ=0 -> VLD=0, ENC=0, GNT=0.
//   3. RR=1, LOCK=0, REQ=8'hFF held for 9 cycles
//      -> ENC = 0,1,2,3,4,5,6,7,0 on successive edges.
//   4. RR=1 after a grant to 5 (PTR=6), REQ=8'b0000_0011
//      -> ENC=0 (wrap); next cycle ENC=1.
//   5. RR=1, ENC=3 granted, LOCK=1, REQ=8'h0C for 4 cycles -> ENC stays 3.
//      Clear REQ[3] -> next edge ENC=2.
//   6. N=5, RR=1, REQ=5'b11111
//      -> ENC = 0,1,2,3,4,0 with no out-of-range index.

Source files
------------

// File: rtl/rr_priority_arbiter.sv
// Registered N-way arbiter: fixed priority (highest index wins) or round-robin, with a grant-hold LOCK.
// Latency: one cycle. GNT/ENC/VLD at edge k+1 reflect REQ/LOCK sampled at edge k.
// Backpressure: none. Requests are not latched; a request dropped before it wins is lost.
//
// Ports:
//   CLK    rising-edge clock
//   RST_N  asynchronous active-low reset (clears grant and round-robin pointer)
//   REQ    [N-1:0] request vector, bit i = requester i wants the resource
//   LOCK   hold the current grant while its requester keeps REQ asserted
//   GNT    [N-1:0] registered one-hot grant, zero when VLD=0
//   ENC    [W-1:0] registered index of the granted requester, zero when VLD=0
//   VLD    registered grant-valid flag

module rr_priority_arbiter #(
  parameter int N  = 8,
  parameter bit RR = 1'b1,
  localparam int W = $clog2(N)
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [N-1:0] REQ,
  input  logic         LOCK,
  output logic [N-1:0] GNT,
  output logic [W-1:0] ENC,
  output logic         VLD
);

  logic [N-1:0] gnt_q;
  logic [W-1:0] enc_q;
  logic         vld_q;
  logic [W-1:0] ptr_q;     // round-robin search start, always < N

  logic         any_req;
  logic         hold;

  logic [W-1:0] fp_idx;
  logic [N-1:0] hi_req;
  logic         hi_hit;
  logic [W-1:0] hi_idx;
  logic [W-1:0] lo_idx;
  logic [W-1:0] rr_idx;
  logic [W-1:0] win_idx;
  logic [N-1:0] win_oh;
  logic [W-1:0] ptr_nxt;

  assign any_req = |REQ;

  // The owner keeps the resource only while it still asks for it; once it
  // drops its request the arbiter picks a new winner in the same cycle.
  assign hold = vld_q & LOCK & REQ[enc_q];

  // Fixed priority: the last set bit seen in an ascending scan is the
  // highest index.
  always_comb begin
    fp_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (REQ[i]) fp_idx = W'(i);
    end
  end

  // Round-robin: split the requests into those at or above the pointer and
  // all of them. The lowest set bit of the upper slice wins if any exists,
  // otherwise the search has wrapped and the lowest set bit overall wins.
  always_comb begin
    hi_req = '0;
    for (int i = 0; i < N; i++) begin
      hi_req[i] = REQ[i] && (W'(i) >= ptr_q);
    end
  end

  assign hi_hit = |hi_req;

  // Descending scan so the lowest set index is the one left standing.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hi_req[i]) hi_idx = W'(i);
      if (REQ[i])    lo_idx = W'(i);
    end
  end

  assign rr_idx  = hi_hit ? hi_idx : lo_idx;
  assign win_idx = RR ? rr_idx : fp_idx;

  always_comb begin
    win_oh = '0;
    for (int i = 0; i < N; i++) begin
      win_oh[i] = (win_idx == W'(i));
    end
  end

  // Explicit compare keeps the pointer inside 0..N-1 when N is not a power
  // of two.
  assign ptr_nxt = (win_idx == W'(N - 1)) ? '0 : win_idx + W'(1);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      gnt_q <= '0;
      enc_q <= '0;
      vld_q <= 1'b0;
      ptr_q <= '0;
    end else if (hold) begin
      gnt_q <= gnt_q;
      enc_q <= enc_q;
      vld_q <= vld_q;
      ptr_q <= ptr_q;
    end else if (!any_req) begin
      gnt_q <= '0;
      enc_q <= '0;
      vld_q <= 1'b0;
    end else begin
      gnt_q <= win_oh;
      enc_q <= win_idx;
      vld_q <= 1'b1;
      if (RR) ptr_q <= ptr_nxt;
    end
  end

  assign GNT = gnt_q;
  assign ENC = enc_q;
  assign VLD = vld_q;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
module tb_rr_priority_arbiter;

  logic       CLK = 1'b0;
  logic       RST_N;

  logic [7:0] req8, reqf;
  logic [4:0] req5;
  logic       lock8, lockf, lock5;
  logic [7:0] gnt8, gntf;
  logic [4:0] gnt5;
  logic [2:0] enc8, encf, enc5;
  logic       vld8, vldf, vld5;

  always #5 CLK = ~CLK;

  rr_priority_arbiter #(.N(8), .RR(1'b1)) u_rr8 (
    .CLK(CLK), .RST_N(RST_N), .REQ(req8), .LOCK(lock8),
    .GNT(gnt8), .ENC(enc8), .VLD(vld8)
  );

  rr_priority_arbiter #(.N(8), .RR(1'b0)) u_fp8 (
    .CLK(CLK), .RST_N(RST_N), .REQ(reqf), .LOCK(lockf),
    .GNT(gntf), .ENC(encf), .VLD(vldf)
  );

  rr_priority_arbiter #(.N(5), .RR(1'b1)) u_rr5 (
    .CLK(CLK), .RST_N(RST_N), .REQ(req5), .LOCK(lock5),
    .GNT(gnt5), .ENC(enc5), .VLD(vld5)
  );

  typedef struct packed {
    logic [7:0] req;
    logic       lock;
    logic [2:0] enc;
    logic       vld;
  } vec_t;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] req;
    logic [2:0] enc;
    logic       vld;
  } exp_t;

  exp_t sb[$];

  int n_pass  = 0;
  int n_total = 0;

  vec_t tv_rr8[25];
  vec_t tv_fp8[10];
  vec_t tv_rr5[10];

  function automatic vec_t mk(input logic [7:0] r, input logic l,
                              input logic [2:0] e, input logic v);
    vec_t t;
    t.req  = r;
    t.lock = l;
    t.enc  = e;
    t.vld  = v;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Drive one vector into the selected instance, record the expectation,
  // then compare one cycle later against the oldest scoreboard entry.
  task automatic run_vec(input int sel, input int idx, input vec_t v, input string tag);
    exp_t       e;
    logic [7:0] a_gnt;
    logic [2:0] a_enc;
    logic       a_vld;
    logic [7:0] e_gnt;
    case (sel)
      0: begin req8 = v.req;      lock8 = v.lock; end
      1: begin reqf = v.req;      lockf = v.lock; end
      default: begin req5 = v.req[4:0]; lock5 = v.lock; end
    endcase
    sb.push_back({2'(sel), v.req, v.enc, v.vld});
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      check($sformatf("%s[%0d].sb_empty", tag, idx), 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      case (e.sel)
        2'd0:    begin a_gnt = gnt8;         a_enc = enc8; a_vld = vld8; end
        2'd1:    begin a_gnt = gntf;         a_enc = encf; a_vld = vldf; end
        default: begin a_gnt = {3'b0, gnt5}; a_enc = enc5; a_vld = vld5; end
      endcase
      e_gnt = e.vld ? (8'd1 << e.enc) : 8'd0;
      check($sformatf("%s[%0d].vld", tag, idx), 32'(a_vld), 32'(e.vld));
      check($sformatf("%s[%0d].enc", tag, idx), 32'(a_enc), 32'(e.enc));
      check($sformatf("%s[%0d].gnt", tag, idx), 32'(a_gnt), 32'(e_gnt));
      check($sformatf("%s[%0d].gnt_onehot0", tag, idx), 32'($onehot0(a_gnt)), 32'd1);
      check($sformatf("%s[%0d].granted_bit_requested", tag, idx),
            32'(!a_vld || e.req[a_enc]), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Round-robin N=8, starting from reset (PTR=0).
    for (int i = 0; i < 9; i++) tv_rr8[i] = mk(8'hFF, 1'b0, 3'(i % 8), 1'b1);
    tv_rr8[9]  = mk(8'h20, 1'b0, 3'd5, 1'b1);  // PTR -> 6
    tv_rr8[10] = mk(8'h03, 1'b0, 3'd0, 1'b1);  // wrap past 7
    tv_rr8[11] = mk(8'h03, 1'b0, 3'd1, 1'b1);
    tv_rr8[12] = mk(8'h00, 1'b0, 3'd0, 1'b0);  // idle, PTR stays 2
    tv_rr8[13] = mk(8'h88, 1'b0, 3'd3, 1'b1);  // PTR -> 4
    for (int i = 14; i < 18; i++) tv_rr8[i] = mk(8'h0C, 1'b1, 3'd3, 1'b1);
    tv_rr8[18] = mk(8'h04, 1'b1, 3'd2, 1'b1);  // owner drops, search from 4
    tv_rr8[19] = mk(8'h04, 1'b1, 3'd2, 1'b1);
    tv_rr8[20] = mk(8'h00, 1'b1, 3'd0, 1'b0);
    tv_rr8[21] = mk(8'h11, 1'b1, 3'd4, 1'b1);  // LOCK ignored with VLD=0, PTR 3
    tv_rr8[22] = mk(8'h11, 1'b0, 3'd0, 1'b1);  // from 5 wraps to 0
    tv_rr8[23] = mk(8'h11, 1'b1, 3'd0, 1'b1);  // hold
    tv_rr8[24] = mk(8'h10, 1'b1, 3'd4, 1'b1);  // drop, search from 1

    // Fixed priority N=8.
    tv_fp8[0] = mk(8'h2C, 1'b0, 3'd5, 1'b1);
    tv_fp8[1] = mk(8'h00, 1'b0, 3'd0, 1'b0);
    tv_fp8[2] = mk(8'h01, 1'b0, 3'd0, 1'b1);
    tv_fp8[3] = mk(8'h81, 1'b0, 3'd7, 1'b1);
    tv_fp8[4] = mk(8'hFF, 1'b1, 3'd7, 1'b1);
    tv_fp8[5] = mk(8'h7F, 1'b1, 3'd6, 1'b1);
    tv_fp8[6] = mk(8'hFF, 1'b1, 3'd6, 1'b1);   // lock beats higher index
    tv_fp8[7] = mk(8'hFF, 1'b0, 3'd7, 1'b1);
    tv_fp8[8] = mk(8'h00, 1'b1, 3'd0, 1'b0);
    tv_fp8[9] = mk(8'h02, 1'b1, 3'd1, 1'b1);

    // Round-robin N=5, non-power-of-two wrap.
    for (int i = 0; i < 6; i++) tv_rr5[i] = mk(8'h1F, 1'b0, 3'(i % 5), 1'b1);
    tv_rr5[6] = mk(8'h10, 1'b0, 3'd4, 1'b1);   // PTR wraps 4 -> 0
    tv_rr5[7] = mk(8'h11, 1'b0, 3'd0, 1'b1);
    tv_rr5[8] = mk(8'h06, 1'b0, 3'd1, 1'b1);
    tv_rr5[9] = mk(8'h01, 1'b0, 3'd0, 1'b1);   // from 2 wraps to 0

    RST_N = 1'b0;
    req8 = 8'hFF; reqf = 8'hFF; req5 = 5'h1F;
    lock8 = 1'b0; lockf = 1'b0; lock5 = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("pre_reset.rr8_enc", 32'(enc8), 32'd1);
    check("pre_reset.rr8_vld", 32'(vld8), 32'd1);
    check("pre_reset.fp8_enc", 32'(encf), 32'd7);
    check("pre_reset.rr5_enc", 32'(enc5), 32'd1);

    // Mid-cycle asynchronous reset with all requests still asserted.
    #3 RST_N = 1'b0;
    #1;
    check("async_reset.rr8_gnt", 32'(gnt8), 32'd0);
    check("async_reset.rr8_enc", 32'(enc8), 32'd0);
    check("async_reset.rr8_vld", 32'(vld8), 32'd0);
    check("async_reset.fp8_gnt", 32'(gntf), 32'd0);
    check("async_reset.fp8_enc", 32'(encf), 32'd0);
    check("async_reset.fp8_vld", 32'(vldf), 32'd0);
    check("async_reset.rr5_gnt", 32'(gnt5), 32'd0);
    check("async_reset.rr5_enc", 32'(enc5), 32'd0);
    check("async_reset.rr5_vld", 32'(vld5), 32'd0);

    req8 = 8'h00; reqf = 8'h00; req5 = 5'h00;
    @(posedge CLK); #1;
    check("reset_held.rr8_vld", 32'(vld8), 32'd0);
    RST_N = 1'b1;

    for (int i = 0; i < 25; i++) run_vec(0, i, tv_rr8[i], "rr8");
    req8 = 8'h00; lock8 = 1'b0;
    for (int i = 0; i < 10; i++) run_vec(1, i, tv_fp8[i], "fp8");
    reqf = 8'h00; lockf = 1'b0;
    for (int i = 0; i < 10; i++) run_vec(2, i, tv_rr5[i], "rr5");
    req5 = 5'h00; lock5 = 1'b0;

    // Both other instances idle after their inputs were cleared.
    @(posedge CLK); #1;
    check("idle.rr8_vld", 32'(vld8), 32'd0);
    check("idle.fp8_vld", 32'(vldf), 32'd0);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
